sel_mux_pipe: RTL and testbench

Parametrised successor to the 64-bit 8:1 ALU result mux. It selects one of NUM_INPUTS WIDTH-bit operands by a binary select and registers the result behind a valid/ready handshake. A 2-entry skid buffer sustains one transfer per cycle under back-pressure. It also flags out-of-range selects and counts them. It sits between the ALU function units and the writeback/forwarding path.

---
 rtl/sel_mux_pipe.sv | 106 ++++++++++
 tb/tb_sel_mux_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sel_mux_pipe
//  Description : NUM_INPUTS:1 WIDTH-bit operand mux with binary select and a
//                registered valid/ready output stage. An output register plus
//                one skid register keep one beat per cycle under back-pressure.
//                Out-of-range selects return zero data, raise out_err and are
//                counted in a saturating counter when the beat is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module sel_mux_pipe #(
   parameter int WIDTH      = 64,
   parameter int NUM_INPUTS = 8,
   parameter int SEL_WIDTH  = 3,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
   input  logic [SEL_WIDTH-1:0]        in_sel,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [SEL_WIDTH-1:0]        out_sel,
   output logic                        out_err,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CNT_WIDTH-1:0]        err_count
);

   // Reject configurations the select cannot address or that make no sense.
   if ((NUM_INPUTS > (2 ** SEL_WIDTH)) || (NUM_INPUTS < 2)) begin : g_cfg_error
      $fatal(1, "sel_mux_pipe: NUM_INPUTS must be in 2..2**SEL_WIDTH");
   end

   logic [WIDTH-1:0]     mux_data;
   logic                 mux_err;
   logic                 accept;
   logic                 o_free;
   logic                 s_full;
   logic [WIDTH-1:0]     s_data;
   logic [SEL_WIDTH-1:0] s_sel;
   logic                 s_err;

   // Flat compare-and-select: exactly one channel can match, so no priority.
   always_comb begin
      mux_data = '0;
      mux_err  = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (in_sel == SEL_WIDTH'(i)) begin
            mux_data = in_data[i*WIDTH +: WIDTH];
            mux_err  = 1'b0;
         end
      end
   end

   // Ready depends only on registered state so no combinational loop forms.
   assign in_ready = reset & ~s_full;
   assign accept   = in_valid & in_ready;
   assign o_free   = ~out_valid | out_ready;

   // Output register and skid register: skid drains first to keep FIFO order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         out_err   <= 1'b0;
         s_full    <= 1'b0;
         s_data    <= '0;
         s_sel     <= '0;
         s_err     <= 1'b0;
      end else if (o_free) begin
         if (s_full) begin
            out_valid <= 1'b1;
            out_data  <= s_data;
            out_sel   <= s_sel;
            out_err   <= s_err;
            s_full    <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_sel   <= in_sel;
            out_err   <= mux_err;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         s_full <= 1'b1;
         s_data <= mux_data;
         s_sel  <= in_sel;
         s_err  <= mux_err;
      end
   end

   // Count bad selects when accepted, holding at all-ones instead of wrapping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         err_count <= '0;
      end else if (accept && mux_err && (err_count != {CNT_WIDTH{1'b1}})) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sel_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sel_mux_pipe
//  Description : Directed bench for sel_mux_pipe. Three instances share one
//                stimulus stream: dut0 uses defaults, dut1 has five channels,
//                dut2 has five channels and a 2-bit error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_mux_pipe;

   logic         clock = 1'b0;
   logic         reset;
   logic [511:0] in_data;
   logic [2:0]   in_sel;
   logic         in_valid;
   logic         out_ready;

   logic         in_ready0, in_ready1, in_ready2;
   logic [63:0]  out_data0, out_data1, out_data2;
   logic [2:0]   out_sel0, out_sel1, out_sel2;
   logic         out_err0, out_err1, out_err2;
   logic         out_valid0, out_valid1, out_valid2;
   logic [7:0]   err_count0, err_count1;
   logic [1:0]   err_count2;

   int checks   = 0;
   int failures = 0;

   logic [63:0] chv [8];

   always #5 clock = ~clock;

   sel_mux_pipe dut0 (
      .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0),
      .out_sel(out_sel0), .out_err(out_err0), .out_valid(out_valid0),
      .out_ready(out_ready), .err_count(err_count0)
   );

   sel_mux_pipe #(.WIDTH(64), .NUM_INPUTS(5), .SEL_WIDTH(3), .CNT_WIDTH(8)) dut1 (
      .clock(clock), .reset(reset), .in_data(in_data[319:0]), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1),
      .out_sel(out_sel1), .out_err(out_err1), .out_valid(out_valid1),
      .out_ready(out_ready), .err_count(err_count1)
   );

   sel_mux_pipe #(.WIDTH(64), .NUM_INPUTS(5), .SEL_WIDTH(3), .CNT_WIDTH(2)) dut2 (
      .clock(clock), .reset(reset), .in_data(in_data[319:0]), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
      .out_sel(out_sel2), .out_err(out_err2), .out_valid(out_valid2),
      .out_ready(out_ready), .err_count(err_count2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic short_reset();
      in_valid = 1'b0;
      reset    = 1'b0;
      tick();
      reset    = 1'b1;
   endtask

   initial begin
      chv[0] = 64'h0000_0000_0000_0000;
      chv[1] = 64'h1111_0000_0000_0001;
      chv[2] = 64'h2222_0000_0000_0002;
      chv[3] = 64'h3333_0000_0000_0003;
      chv[4] = 64'h4444_0000_0000_0004;
      chv[5] = 64'h5555_0000_0000_0005;
      chv[6] = 64'h6666_0000_0000_0006;
      chv[7] = 64'h7777_0000_0000_0007;
      for (int i = 0; i < 8; i++) in_data[i*64 +: 64] = chv[i];

      // Reset held three cycles with a pending beat
      reset = 1'b0; in_valid = 1'b1; in_sel = 3'd2; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_in_ready", in_ready0, 0);
         check("rst_out_valid", out_valid0, 0);
      end
      check("rst_out_data", out_data0, 0);
      check("rst_out_sel", out_sel0, 0);
      check("rst_out_err", out_err0, 0);
      check("rst_err_count", err_count0, 0);
      reset = 1'b1; in_valid = 1'b0;
      tick();
      check("rst_release_in_ready", in_ready0, 1);
      check("rst_release_out_valid", out_valid0, 0);

      // Full sweep: one beat per cycle, 1-cycle latency
      short_reset();
      out_ready = 1'b1;
      for (int s = 0; s < 8; s++) begin
         in_sel = 3'(s); in_valid = 1'b1;
         tick();
         check("sweep_valid", out_valid0, 1);
         check("sweep_data", out_data0, chv[s]);
         check("sweep_sel", out_sel0, 64'(s));
         check("sweep_err", out_err0, 0);
         check("sweep_in_ready", in_ready0, 1);
      end
      in_valid = 1'b0;
      tick();
      check("sweep_drain_valid", out_valid0, 0);
      check("sweep_hold_data", out_data0, chv[7]);
      check("sweep_err_count", err_count0, 0);

      // Out-of-range selects on the five-channel instance
      short_reset();
      out_ready = 1'b1;
      for (int s = 5; s < 8; s++) begin
         in_sel = 3'(s); in_valid = 1'b1;
         tick();
         check("oor_valid", out_valid1, 1);
         check("oor_data", out_data1, 0);
         check("oor_err", out_err1, 1);
         check("oor_sel", out_sel1, 64'(s));
         check("oor_count", err_count1, 64'(s - 4));
      end
      in_sel = 3'd4;
      tick();
      check("oor_ch4_data", out_data1, chv[4]);
      check("oor_ch4_err", out_err1, 0);
      check("oor_ch4_count", err_count1, 3);
      check("oor_dut0_count", err_count0, 0);
      in_valid = 1'b0;

      // Back-pressure: A into O, B into skid, hold, then drain in order
      short_reset();
      out_ready = 1'b0;
      in_sel = 3'd1; in_valid = 1'b1;
      tick();
      check("bp_a_valid", out_valid0, 1);
      check("bp_a_in_ready", in_ready0, 1);
      in_sel = 3'd2;
      tick();
      check("bp_b_in_ready", in_ready0, 0);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_data", out_data0, chv[1]);
         check("bp_hold_sel", out_sel0, 1);
         check("bp_hold_valid", out_valid0, 1);
         check("bp_hold_in_ready", in_ready0, 0);
         tick();
      end
      check("bp_pre_release_data", out_data0, chv[1]);
      out_ready = 1'b1;
      tick();
      check("bp_b_data", out_data0, chv[2]);
      check("bp_b_sel", out_sel0, 2);
      check("bp_b_valid", out_valid0, 1);
      check("bp_ready_back", in_ready0, 1);
      tick();
      check("bp_empty", out_valid0, 0);

      // Saturation with a 2-bit counter
      short_reset();
      out_ready = 1'b1;
      in_sel = 3'd7; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("sat_count", err_count2, (i < 3) ? 64'(i + 1) : 64'd3);
      end
      in_valid = 1'b0;

      // Reset while O and skid are both full
      short_reset();
      out_ready = 1'b0;
      in_sel = 3'd1; in_valid = 1'b1;
      tick();
      in_sel = 3'd2;
      tick();
      check("mid_stall_full", in_ready0, 0);
      in_valid = 1'b0;
      reset = 1'b0;
      tick();
      check("mid_rst_valid", out_valid0, 0);
      check("mid_rst_in_ready", in_ready0, 0);
      reset = 1'b1;
      #1;
      check("mid_release_in_ready", in_ready0, 1);
      out_ready = 1'b1;
      in_sel = 3'd3; in_valid = 1'b1;
      tick();
      check("mid_new_data", out_data0, chv[3]);
      check("mid_new_sel", out_sel0, 3);
      check("mid_new_valid", out_valid0, 1);
      in_valid = 1'b0;
      tick();
      check("mid_no_stale", out_valid0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
